// File: rtl/bin2seg_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) driving
// DIGITS seven-segment patterns with leading-zero blanking and overflow dashes.
module bin2seg_seq #(
  parameter int WIDTH          = 14,
  parameter int DIGITS         = 5,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;

  localparam logic [6:0] PAT_ZERO  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [6:0] PAT_DASH  = SEG_ACTIVE_LOW ? 7'h3F : 7'h40;
  localparam logic [6:0] PAT_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     acc;
  logic [BW-1:0]     adj;
  logic              carry;
  logic              blz;
  logic [CW-1:0]     cnt;
  logic [7*DIGITS-1:0] seg_next;
  logic [3:0]        dig;
  logic [6:0]        pat;
  logic              lead;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 7'h3F;
      4'd1:    seg_lut = 7'h06;
      4'd2:    seg_lut = 7'h5B;
      4'd3:    seg_lut = 7'h4F;
      4'd4:    seg_lut = 7'h66;
      4'd5:    seg_lut = 7'h6D;
      4'd6:    seg_lut = 7'h7D;
      4'd7:    seg_lut = 7'h07;
      4'd8:    seg_lut = 7'h7F;
      4'd9:    seg_lut = 7'h6F;
      default: seg_lut = 7'h00;
    endcase
  endfunction

  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; digits stay blank until the first nonzero one.
  always_comb begin
    seg_next = '0;
    dig      = '0;
    pat      = '0;
    lead     = blz;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = acc[4*i +: 4];
      if (dig != 4'd0)
        lead = 1'b0;
      if (lead && i > 0)
        pat = 7'h00;
      else
        pat = seg_lut(dig);
      seg_next[7*i +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      blz      <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bcd      <= '0;
      seg      <= {DIGITS{PAT_ZERO}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= in;
            blz   <= blank_lz;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= {adj[BW-2:0], shreg[WIDTH-1]};
          shreg <= shreg << 1;
          carry <= carry | adj[BW-1];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= LOAD;
        end
        LOAD: begin
          overflow <= carry;
          bcd      <= carry ? {DIGITS{4'h9}} : acc;
          seg      <= carry ? {DIGITS{PAT_DASH}} : seg_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Blank pattern only appears through seg_next; keep the constant for readers.
  logic unused_blank;
  assign unused_blank = ^PAT_BLANK;

endmodule
